// File: rtl/reg_scoreboard.sv
// reg_scoreboard: in-order destination-register scoreboard for the 5-stage
// pipeline. Shadows the EX/MEM/WB stages with {valid, rd} slots, raises
// stall_id for unresolved RAW hazards in ID, and checks each retirement
// against the real MEM/WB regfile write port (sticky sb_err).
//
// Build option: define SCOREBOARD_FWD_EN when MEM/WB forwarding supplies the
// wb-slot value, so consumers stop stalling once the producer reaches wb.
// Left undefined (default), a producer in wb still blocks its consumers.
module reg_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int NREGS      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_rs1,
    input  logic                  id_rs1_ren,
    input  logic [ADDR_WIDTH-1:0] id_rs2,
    input  logic                  id_rs2_ren,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic                  id_rd_wen,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  wb_wen,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    output logic                  stall_id,
    output logic                  id_fire,
    output logic [NREGS-1:0]      busy,
    output logic [1:0]            inflight_cnt,
    output logic                  sb_err
);

`ifdef SCOREBOARD_FWD_EN
    localparam bit WB_BLOCKS = 1'b0;
`else
    localparam bit WB_BLOCKS = 1'b1;
`endif

    logic                  ex_v_q,  ex_v_d;
    logic [ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
    logic                  mem_v_q,  mem_v_d;
    logic [ADDR_WIDTH-1:0] mem_rd_q, mem_rd_d;
    logic                  wb_v_q,  wb_v_d;
    logic [ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic                  sb_err_q, sb_err_d;
    logic                  adv;
    logic                  rs1_hit, rs2_hit;

    function automatic logic src_hit(
        input logic                  ren,
        input logic [ADDR_WIDTH-1:0] src,
        input logic                  exv,
        input logic [ADDR_WIDTH-1:0] exrd,
        input logic                  memv,
        input logic [ADDR_WIDTH-1:0] memrd,
        input logic                  wbv,
        input logic [ADDR_WIDTH-1:0] wbrd
    );
        return ren && (src != '0) &&
               ((exv && (exrd == src)) ||
                (memv && (memrd == src)) ||
                (WB_BLOCKS && wbv && (wbrd == src)));
    endfunction

    // Hazard detection and issue decision for the ID instruction
    always_comb begin
        adv      = !hold;
        rs1_hit  = src_hit(id_rs1_ren, id_rs1, ex_v_q, ex_rd_q, mem_v_q, mem_rd_q, wb_v_q, wb_rd_q);
        rs2_hit  = src_hit(id_rs2_ren, id_rs2, ex_v_q, ex_rd_q, mem_v_q, mem_rd_q, wb_v_q, wb_rd_q);
        // flush wins over stall: a killed instruction neither stalls nor issues
        stall_id = id_valid && !flush && (rs1_hit || rs2_hit);
        // gated by rst_n so nothing appears to issue while reset is held
        id_fire  = rst_n && id_valid && !flush && !stall_id && !hold;
    end

    // Slot advance and retirement cross-check
    always_comb begin
        ex_v_d   = ex_v_q;
        ex_rd_d  = ex_rd_q;
        mem_v_d  = mem_v_q;
        mem_rd_d = mem_rd_q;
        wb_v_d   = wb_v_q;
        wb_rd_d  = wb_rd_q;
        sb_err_d = sb_err_q;
        if (adv) begin
            wb_v_d   = mem_v_q;
            wb_rd_d  = mem_rd_q;
            mem_v_d  = ex_v_q;
            mem_rd_d = ex_rd_q;
            // x0 writes are architecturally void, so they never occupy a slot
            ex_v_d   = id_fire && id_rd_wen && (id_rd != '0);
            ex_rd_d  = id_rd;
            if (wb_v_q) begin
                if (!wb_wen || (wb_waddr != wb_rd_q)) begin
                    sb_err_d = 1'b1;
                end
            end else if (wb_wen && (wb_waddr != '0)) begin
                sb_err_d = 1'b1;
            end
        end
    end

    // Slot and error-flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q   <= 1'b0;
            ex_rd_q  <= '0;
            mem_v_q  <= 1'b0;
            mem_rd_q <= '0;
            wb_v_q   <= 1'b0;
            wb_rd_q  <= '0;
            sb_err_q <= 1'b0;
        end else begin
            ex_v_q   <= ex_v_d;
            ex_rd_q  <= ex_rd_d;
            mem_v_q  <= mem_v_d;
            mem_rd_q <= mem_rd_d;
            wb_v_q   <= wb_v_d;
            wb_rd_q  <= wb_rd_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Busy vector and occupancy derived from the slots
    always_comb begin
        busy = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy[r] = (ex_v_q  && (ex_rd_q  == ADDR_WIDTH'(r))) ||
                      (mem_v_q && (mem_rd_q == ADDR_WIDTH'(r))) ||
                      (wb_v_q  && (wb_rd_q  == ADDR_WIDTH'(r)));
        end
        inflight_cnt = {1'b0, ex_v_q} + {1'b0, mem_v_q} + {1'b0, wb_v_q};
        sb_err       = sb_err_q;
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: a hand-computed vector table for the
// producer/consumer latency, directed sequences for reset, x0, hold, flush
// and retirement errors, then randomized traffic against a queue-based model.
module tb_reg_scoreboard;
    localparam int AW = 5;
    localparam int NR = 32;
`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid, id_rs1_ren, id_rs2_ren, id_rd_wen, hold, flush, wb_wen;
    logic [AW-1:0] id_rs1, id_rs2, id_rd, wb_waddr;
    logic          stall_id, id_fire, sb_err;
    logic [NR-1:0] busy;
    logic [1:0]    inflight_cnt;

    reg_scoreboard #(.ADDR_WIDTH(AW), .NREGS(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_ren(id_rs1_ren),
        .id_rs2(id_rs2), .id_rs2_ren(id_rs2_ren), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
        .hold(hold), .flush(flush), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
        .stall_id(stall_id), .id_fire(id_fire), .busy(busy),
        .inflight_cnt(inflight_cnt), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [AW-1:0] rs1;
        logic          r1en;
        logic [AW-1:0] rs2;
        logic          r2en;
        logic [AW-1:0] rd;
        logic          rdwen;
        logic          hold;
        logic          flush;
        logic          wbwen;
        logic [AW-1:0] wbaddr;
    } in_t;

    typedef struct {
        in_t        in;
        logic       stall;
        logic       fire;
        logic [1:0] cnt;
        logic       busy5;
    } vec_t;

    typedef struct {
        int rd;
        int age;
    } prod_t;

    int     n_checks = 0;
    int     n_fail = 0;
    prod_t  pq[$];
    bit     m_err;
    vec_t   tbl[5];
    in_t    idle, cur;

    function automatic in_t mk_in(input logic v, input logic [AW-1:0] rs1, input logic r1en,
                                  input logic [AW-1:0] rs2, input logic r2en,
                                  input logic [AW-1:0] rd, input logic rdwen,
                                  input logic hld, input logic fl,
                                  input logic wbwen, input logic [AW-1:0] wbaddr);
        in_t t;
        t.v = v; t.rs1 = rs1; t.r1en = r1en; t.rs2 = rs2; t.r2en = r2en;
        t.rd = rd; t.rdwen = rdwen; t.hold = hld; t.flush = fl;
        t.wbwen = wbwen; t.wbaddr = wbaddr;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic apply(input in_t t);
        id_valid = t.v; id_rs1 = t.rs1; id_rs1_ren = t.r1en; id_rs2 = t.rs2;
        id_rs2_ren = t.r2en; id_rd = t.rd; id_rd_wen = t.rdwen; hold = t.hold;
        flush = t.flush; wb_wen = t.wbwen; wb_waddr = t.wbaddr;
    endtask

    // drive at the falling edge, then settle to just before the rising edge
    task automatic drive(input in_t t);
        apply(t);
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    // In-flight producers are kept as {rd, age}; age 1/2/3 = cycles since issue.
    function automatic bit m_match(input int x, input bit ren);
        if (!ren || x == 0) return 1'b0;
        foreach (pq[i]) begin
            if (pq[i].rd == x && (pq[i].age <= 2 || (!FWD && pq[i].age == 3))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        foreach (pq[i]) b[pq[i].rd] = 1'b1;
        return b;
    endfunction

    function automatic int m_wb_rd();
        foreach (pq[i]) if (pq[i].age == 3) return pq[i].rd;
        return -1;
    endfunction

    task automatic m_edge(input in_t t, input bit fired);
        int w;
        if (t.hold) return;
        w = m_wb_rd();
        if (w >= 0) begin
            if (!t.wbwen || int'(t.wbaddr) != w) m_err = 1'b1;
        end else if (t.wbwen && t.wbaddr != 0) begin
            m_err = 1'b1;
        end
        foreach (pq[i]) pq[i].age++;
        while (pq.size() > 0 && pq[0].age > 3) void'(pq.pop_front());
        if (fired && t.rdwen && t.rd != 0) pq.push_back('{rd: int'(t.rd), age: 1});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(idle);
        #1;
        check("reset_busy", busy, 32'h0);
        check("reset_cnt", inflight_cnt, 0);
        check("reset_stall", stall_id, 0);
        check("reset_fire", id_fire, 0);
        check("reset_err", sb_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pq.delete();
        m_err = 1'b0;
    endtask

    initial begin
        in_t c5, c7, t;
        idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(idle);
        m_err = 1'b0;
        @(negedge clk);
        do_reset();

        // ---- table: producer rd=5, consumer rs1=5 ----
        c5 = mk_in(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        tbl[0] = '{in: mk_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0), stall: 0, fire: 1, cnt: 0, busy5: 0};
        tbl[1] = '{in: c5, stall: 1, fire: 0, cnt: 1, busy5: 1};
        tbl[2] = '{in: c5, stall: 1, fire: 0, cnt: 1, busy5: 1};
        t = c5; t.wbwen = 1; t.wbaddr = 5;
        tbl[3] = '{in: t, stall: !FWD, fire: FWD, cnt: 1, busy5: 1};
        tbl[4] = '{in: c5, stall: 0, fire: 1, cnt: FWD ? 2'd1 : 2'd0, busy5: 0};
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].in);
            check($sformatf("tbl%0d_stall", i), stall_id, tbl[i].stall);
            check($sformatf("tbl%0d_fire", i), id_fire, tbl[i].fire);
            check($sformatf("tbl%0d_cnt", i), inflight_cnt, tbl[i].cnt);
            check($sformatf("tbl%0d_busy5", i), busy[5], tbl[i].busy5);
            check($sformatf("tbl%0d_err", i), sb_err, 0);
            tick();
        end

        // ---- asynchronous reset mid-flight ----
        do_reset();
        drive(tbl[0].in);
        tick();
        drive(c5);
        check("mid_busy_pre", busy, 32'h20);
        check("mid_stall_pre", stall_id, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 32'h0);
        check("mid_cnt", inflight_cnt, 0);
        check("mid_stall", stall_id, 0);
        check("mid_fire", id_fire, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- x0 producer / x0 consumer ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(mk_in(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
            check($sformatf("x0_stall%0d", i), stall_id, 0);
            check($sformatf("x0_cnt%0d", i), inflight_cnt, 0);
            check($sformatf("x0_fire%0d", i), id_fire, 1);
            tick();
        end

        // ---- hold with rd=7 in mem ----
        do_reset();
        drive(mk_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0));
        check("hold_issue", id_fire, 1);
        tick();
        c7 = mk_in(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0);
        drive(c7);
        check("hold_pre_stall", stall_id, 1);
        tick();
        t = c7; t.hold = 1; t.wbwen = 1; t.wbaddr = 3;
        for (int i = 0; i < 4; i++) begin
            drive(t);
            check($sformatf("hold%0d_stall", i), stall_id, 1);
            check($sformatf("hold%0d_busy", i), busy, 32'h80);
            check($sformatf("hold%0d_cnt", i), inflight_cnt, 1);
            check($sformatf("hold%0d_fire", i), id_fire, 0);
            check($sformatf("hold%0d_err", i), sb_err, 0);
            tick();
        end
        drive(c7);
        check("hold_rel_stall", stall_id, 1);
        check("hold_rel_err", sb_err, 0);
        tick();
        t = c7; t.wbwen = 1; t.wbaddr = 7;
        drive(t);
        check("hold_wb_stall", stall_id, !FWD);
        check("hold_wb_busy7", busy[7], 1);
        tick();
        drive(idle);
        check("hold_post_err", sb_err, 0);
        tick();

        // ---- flush beats stall, never enters ex ----
        do_reset();
        drive(mk_in(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0));
        tick();
        drive(mk_in(1, 4, 1, 0, 0, 9, 1, 0, 1, 0, 0));
        check("flush_stall", stall_id, 0);
        check("flush_fire", id_fire, 0);
        tick();
        drive(idle);
        check("flush_busy", busy, 32'h10);
        check("flush_cnt", inflight_cnt, 1);
        tick();

        // ---- retirement mismatch: wb.rd=3, wb_waddr=4 ----
        do_reset();
        drive(mk_in(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0));
        tick();
        drive(idle);
        tick();
        drive(idle);
        tick();
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4));
        check("err_before", sb_err, 0);
        check("err_wb_busy3", busy, 32'h8);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            check($sformatf("err_sticky%0d", i), sb_err, 1);
            tick();
        end
        do_reset();

        // ---- randomized traffic against the model ----
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int cyc = 0; cyc < 150; cyc++) begin
                int  w;
                bit  es, ef;
                t.v     = ($urandom_range(0, 9) < 8);
                t.rs1   = 5'($urandom_range(0, 7));
                t.r1en  = 1'($urandom_range(0, 1));
                t.rs2   = 5'($urandom_range(0, 7));
                t.r2en  = 1'($urandom_range(0, 1));
                t.rd    = 5'($urandom_range(0, 7));
                t.rdwen = ($urandom_range(0, 9) < 8);
                t.hold  = ($urandom_range(0, 9) < 2);
                t.flush = ($urandom_range(0, 9) < 1);
                w = m_wb_rd();
                if ($urandom_range(0, 39) != 0) begin
                    if (w >= 0) begin
                        t.wbwen = 1'b1; t.wbaddr = 5'(w);
                    end else begin
                        t.wbwen = 1'($urandom_range(0, 1)); t.wbaddr = 5'd0;
                    end
                end else begin
                    t.wbwen = 1'($urandom_range(0, 1)); t.wbaddr = 5'($urandom_range(0, 7));
                end
                drive(t);
                es = t.v && !t.flush && (m_match(int'(t.rs1), t.r1en) || m_match(int'(t.rs2), t.r2en));
                ef = t.v && !t.flush && !es && !t.hold;
                check("rnd_stall", stall_id, es);
                check("rnd_fire", id_fire, ef);
                check("rnd_busy", busy, m_busy());
                check("rnd_cnt", inflight_cnt, pq.size());
                check("rnd_err", sb_err, m_err);
                @(posedge clk);
                m_edge(t, ef);
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- In-order register scoreboard for the 5-stage pipeline. It is the producer-side partner of the EX-stage operand-forwarding logic.
- Tracks every in-flight destination register from ID issue through writeback, in a shadow EX/MEM/WB slot pipeline.
- Asserts stall_id when an ID-stage source operand cannot yet be obtained from the regfile or the MEM/WB forward path.
- Cross-checks each retirement against the real writeback port.

Parameters:
- ADDR_WIDTH, 5, register address width (matches `ADDR_WIDTH in define.v).
- NREGS, 32, number of architectural registers; busy vector width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1  in  ADDR_WIDTH  ID source 1 address.
- id_rs1_ren  in  1  ID uses rs1.
- id_rs2  in  ADDR_WIDTH  ID source 2 address.
- id_rs2_ren  in  1  ID uses rs2.
- id_rd  in  ADDR_WIDTH  ID destination address.
- id_rd_wen  in  1  ID writes rd.
- hold  in  1  global pipeline freeze (multi-cycle memory); no stage advances.
- flush  in  1  kill the ID instruction this cycle (branch redirect).
- wb_wen  in  1  real MEM/WB regfile write enable.
- wb_waddr  in  ADDR_WIDTH  real MEM/WB write address.
- stall_id  out  1  hold IF/ID, inject bubble into EX.
- id_fire  out  1  ID instruction issues this cycle.
- busy  out  NREGS  bit r set while any slot holds rd==r.
- inflight_cnt  out  2  number of valid slots (0..3).
- sb_err  out  1  sticky retirement-mismatch flag.

Behaviour:
- Reset (async, rst_n low):
  - All slots invalid.
  - stall_id=0, id_fire=0, busy=0, inflight_cnt=0, sb_err=0.
  - Effective immediately; any in-flight state is discarded mid-operation.
- Slots: ex, mem, wb, each holding {v, rd}.
- adv = !hold. On a clk rising edge with adv:
  - wb<=mem, mem<=ex.
  - ex<={1, id_rd} if id_fire && id_rd_wen && id_rd!=0; otherwise ex<=invalid.
- hold=1: all slots keep their contents. sb_err is not evaluated.
- match(x) = x_ren && x!=0 && ((ex.v && ex.rd==x) || (mem.v && mem.rd==x) || EXTRA(x)).
  - EXTRA is defined under Optional Feature.
- stall_id = id_valid && !flush && (match(rs1) || match(rs2)). Combinational.
- id_fire = id_valid && !flush && !stall_id && !hold. Combinational.
- flush has priority over stall: a flushed instruction never stalls and never enters ex.
- Retirement check, evaluated on an adv edge:
  - If wb.v, then wb_wen must be 1 and wb_waddr must equal wb.rd; otherwise sb_err<=1.
  - If !wb.v and wb_wen && wb_waddr!=0, then sb_err<=1.
  - sb_err clears only on reset.
- x0 is never tracked and never stalls.
- Multiple in-flight writes to the same rd are legal. busy[r] clears only when no slot holds r.
- busy and inflight_cnt are combinational from the slots. busy[0] is always 0.
- Latency:
  - A producer issued at cycle t sits in ex during t+1, mem during t+2, wb during t+3 (no hold).
  - With the feature on, a dependent instruction issues at t+3. With it off, it issues at t+4.

Optional Feature:
- Macro: SCOREBOARD_FWD_EN.
- Defined: EXTRA(x)=0. The wb slot is satisfied by MEM/WB forwarding, so dependents stall only while the producer is in ex or mem.
- Undefined: EXTRA(x)=(wb.v && wb.rd==x). There is no bypass, so dependents also stall during the producer's wb cycle.

Test Plan:
- Reset with slots populated (issue rd=5 then assert rst_n=0 mid-flight) -> busy=0, inflight_cnt=0, stall_id=0 asynchronously.
- Issue rd=5; next instruction reads rs1=5 -> with FWD_EN: stall_id=1 for 2 cycles, id_fire at t+3. Without FWD_EN: stall 3 cycles, id_fire at t+4.
- Producer writes rd=0, consumer reads rs2=0 -> stall_id never 1; inflight_cnt stays 0.
- hold=1 for 4 cycles with rd=7 in mem -> slots frozen, busy[7]=1 throughout, stall_id stays 1, no sb_err.
- flush=1 with id_valid=1, id_rd=9 -> id_fire=0, stall_id=0, busy[9] never set.
- wb.v with rd=3 but wb_waddr=4 -> sb_err=1 the next cycle and remains 1 until reset.
